// File: rtl/seg_disp_pkg.sv
// Shared types and helpers for the seven-segment display scheduler.
// Digit select is active-low; segments are active-high.
package seg_disp_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] CAT_OFF   = 8'hFF;

   function automatic logic [7:0] digit_cat(input logic [2:0] idx);
      return ~(8'h80 >> idx);
   endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Requester-side bus of the display scheduler: level requests,
// per-requester frames, one-hot grant pulse and ownership status.
interface seg_req_if #(
   parameter int N_REQ = 3
);

   logic [N_REQ-1:0]    req;
   logic [N_REQ*64-1:0] frame_in;
   logic [N_REQ-1:0]    gnt;
   logic [1:0]          owner;
   logic                busy;

   modport master (
      output req,
      output frame_in,
      input  gnt,
      input  owner,
      input  busy
   );

   modport slave (
      input  req,
      input  frame_in,
      output gnt,
      output owner,
      output busy
   );

endinterface

// File: rtl/seg_display_scheduler_scan_driver.sv
// Scan index, digit mux, blank/blink gating and registered seg/cat.
// Optional blink gating is built only when SEG_BLINK_EN is defined.
module seg_scan_driver
   import seg_disp_pkg::*;
#(
   parameter int BLINK_HALF_MS = 250
) (
   input  logic        clk_1kHz,
   input  logic        rst,
   input  logic        en,
   input  logic [63:0] frame,
`ifdef SEG_BLINK_EN
   input  logic [7:0]  blink_mask,
`endif
   output logic [7:0]  seg,
   output logic [7:0]  cat
);

   logic [2:0] idx;
   logic [7:0] digit;
   logic       blank;

   assign digit = frame[{idx, 3'b000} +: 8];

`ifdef SEG_BLINK_EN
   localparam int BW = $clog2(BLINK_HALF_MS + 1);
   localparam logic [BW-1:0] PH_LAST = BW'(BLINK_HALF_MS - 1);

   logic [BW-1:0] ph_cnt;
   logic          ph_on;

   // blink phase: starts "on", flips every BLINK_HALF_MS cycles
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         ph_cnt <= '0;
         ph_on  <= 1'b1;
      end else if (ph_cnt == PH_LAST) begin
         ph_cnt <= '0;
         ph_on  <= ~ph_on;
      end else begin
         ph_cnt <= ph_cnt + 1'b1;
      end
   end

   assign blank = ~en | (~ph_on & blink_mask[idx]);
`else
   logic unused_blink;
   assign unused_blink = ^BLINK_HALF_MS;
   assign blank = ~en;
`endif

   // free-running scan; outputs show digit idx one cycle later
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         idx <= '0;
         seg <= SEG_BLANK;
         cat <= CAT_OFF;
      end else begin
         idx <= idx + 1'b1;
         if (blank) begin
            seg <= SEG_BLANK;
            cat <= CAT_OFF;
         end else begin
            seg <= digit;
            cat <= digit_cat(idx);
         end
      end
   end

endmodule

// File: rtl/seg_display_scheduler.sv
// Fixed-priority display owner arbiter with hold timer and frame buffer.
// Define SEG_BLINK_EN to add the blink_mask port and blink gating.
module seg_display_scheduler #(
   parameter int N_REQ         = 3,
   parameter int HOLD_MS       = 2000,
   parameter int BLINK_HALF_MS = 250
) (
   input  logic        clk_1kHz,
   input  logic        rst,
   input  logic        en,
   input  logic [63:0] bg_frame,
`ifdef SEG_BLINK_EN
   input  logic [7:0]  blink_mask,
`endif
   seg_req_if.slave    bus,
   output logic [7:0]  seg,
   output logic [7:0]  cat
);

   import seg_disp_pkg::*;

   localparam int TW = $clog2(HOLD_MS + 1);
   localparam logic [TW-1:0] T_LOAD = TW'(HOLD_MS - 1);

   state_t           state;
   state_t           state_n;
   logic [TW-1:0]    timer;
   logic [TW-1:0]    timer_n;
   logic [1:0]       owner;
   logic [1:0]       owner_n;
   logic [1:0]       pick;
   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] gnt_n;
   logic [N_REQ-1:0] req_eff;
   logic [63:0]      fbuf;
   logic [63:0]      pick_frame;
   logic [63:0]      src;
   logic             any_req;
   logic             do_grant;

   // lowest pending index wins; a bit being granted right now is ignored
   always_comb begin
      req_eff    = bus.req & ~gnt;
      any_req    = |req_eff;
      pick       = '0;
      pick_frame = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_eff[i]) pick = 2'(i);
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (pick == 2'(i)) pick_frame = bus.frame_in[i*64 +: 64];
      end
   end

   // next state: grant from IDLE, preempt or chain at expiry in HOLD
   always_comb begin
      state_n  = state;
      timer_n  = timer;
      owner_n  = owner;
      gnt_n    = '0;
      do_grant = 1'b0;
      unique case (state)
         IDLE: begin
            do_grant = any_req;
         end
         HOLD: begin
            if (any_req && (pick <= owner)) begin
               do_grant = 1'b1;
            end else if (timer == '0) begin
               if (any_req) do_grant = 1'b1;
               else state_n = IDLE;
            end else begin
               timer_n = timer - 1'b1;
            end
         end
      endcase
      if (do_grant) begin
         state_n = HOLD;
         timer_n = T_LOAD;
         owner_n = pick;
         gnt_n   = N_REQ'(1) << pick;
      end
   end

   // arbiter state, timer, grant pulse and frame buffer
   always_ff @(posedge clk_1kHz) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
         owner <= '0;
         gnt   <= '0;
         fbuf  <= '0;
      end else begin
         state <= state_n;
         timer <= timer_n;
         owner <= owner_n;
         gnt   <= gnt_n;
         if (do_grant) fbuf <= pick_frame;
      end
   end

   assign bus.gnt   = gnt;
   assign bus.owner = owner;
   assign bus.busy  = (state == HOLD);

   assign src = (state == HOLD) ? fbuf : bg_frame;

   seg_scan_driver #(
      .BLINK_HALF_MS(BLINK_HALF_MS)
   ) u_scan (
      .clk_1kHz  (clk_1kHz),
      .rst       (rst),
      .en        (en),
      .frame     (src),
`ifdef SEG_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .seg       (seg),
      .cat       (cat)
   );

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed table-driven bench for seg_display_scheduler.
// Blink sequence is included when SEG_BLINK_EN is defined.
module tb_seg_display_scheduler;

   localparam int N    = 3;
   localparam int HOLD = 8;
   localparam int BH   = 4;

   logic        clk_1kHz = 1'b0;
   logic        rst;
   logic        en;
   logic [63:0] bg_frame;
   logic [7:0]  seg;
   logic [7:0]  cat;
`ifdef SEG_BLINK_EN
   logic [7:0]  blink_mask;
`endif

   seg_req_if #(.N_REQ(N)) bus();

   always #5 clk_1kHz = ~clk_1kHz;

   seg_display_scheduler #(
      .N_REQ        (N),
      .HOLD_MS      (HOLD),
      .BLINK_HALF_MS(BH)
   ) dut (
      .clk_1kHz  (clk_1kHz),
      .rst       (rst),
      .en        (en),
      .bg_frame  (bg_frame),
`ifdef SEG_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .bus       (bus),
      .seg       (seg),
      .cat       (cat)
   );

   typedef struct {
      logic       rst;
      logic       en;
      logic [2:0] req;
      logic [2:0] gnt;
      logic       busy;
      logic [1:0] owner;
      int         src;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp;
   int   n_bad;
   int   idx_m;

   // src 0 = bg_frame, src r+1 = frame of requester r
   function automatic logic [7:0] fdig(input int s, input int k);
      if (s == 0) return 8'(k + 1);
      return 8'((s << 4) | k);
   endfunction

   function automatic logic [7:0] ecat(input int k);
      logic [7:0] one;
      one = 8'h80;
      return ~(one >> k);
   endfunction

   task automatic add(input logic r, input logic e, input logic [2:0] rq,
                      input logic [2:0] g, input logic b,
                      input logic [1:0] o, input int s, input int cnt);
      for (int i = 0; i < cnt; i++) tbl.push_back('{r, e, rq, g, b, o, s});
   endtask

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_1kHz);
      @(negedge clk_1kHz);
   endtask

   initial begin
      logic [7:0] es;
      logic [7:0] ec;
      int         t;
      int         nb;

      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      en = 1'b1;
      bus.req = '0;
`ifdef SEG_BLINK_EN
      blink_mask = 8'h00;
`endif
      for (int k = 0; k < 8; k++) bg_frame[k*8 +: 8] = 8'(k + 1);
      for (int r = 0; r < N; r++)
         for (int k = 0; k < 8; k++)
            bus.frame_in[r*64 + k*8 +: 8] = 8'(((r + 1) << 4) | k);

      //   rst en req    gnt    busy own src cnt
      add(1, 1, 3'b000, 3'b000, 0, 0, 0, 3);
      add(0, 1, 3'b000, 3'b000, 0, 0, 0, 8);
      add(0, 1, 3'b010, 3'b010, 1, 1, 0, 1);
      add(0, 1, 3'b000, 3'b000, 1, 1, 2, 7);
      add(0, 1, 3'b000, 3'b000, 0, 1, 2, 1);
      add(0, 1, 3'b000, 3'b000, 0, 1, 0, 1);
      add(0, 1, 3'b100, 3'b100, 1, 2, 0, 1);
      add(0, 1, 3'b000, 3'b000, 1, 2, 3, 2);
      add(0, 1, 3'b001, 3'b001, 1, 0, 3, 1);
      add(0, 1, 3'b000, 3'b000, 1, 0, 1, 7);
      add(0, 1, 3'b000, 3'b000, 0, 0, 1, 1);
      add(0, 1, 3'b000, 3'b000, 0, 0, 0, 1);
      add(0, 1, 3'b101, 3'b001, 1, 0, 0, 1);
      add(0, 1, 3'b100, 3'b000, 1, 0, 1, 7);
      add(0, 1, 3'b100, 3'b100, 1, 2, 1, 1);
      add(0, 1, 3'b000, 3'b000, 1, 2, 3, 1);
      add(0, 0, 3'b000, 3'b000, 1, 2, 3, 2);
      add(0, 1, 3'b000, 3'b000, 1, 2, 3, 4);
      add(0, 1, 3'b000, 3'b000, 0, 2, 3, 1);
      add(0, 1, 3'b000, 3'b000, 0, 2, 0, 1);
      add(0, 1, 3'b010, 3'b010, 1, 1, 0, 1);
      add(0, 1, 3'b000, 3'b000, 1, 1, 2, 1);
      add(1, 1, 3'b010, 3'b000, 0, 0, 0, 1);
      add(0, 1, 3'b010, 3'b010, 1, 1, 0, 1);
      add(0, 1, 3'b000, 3'b000, 1, 1, 2, 1);

      idx_m = 0;
      @(negedge clk_1kHz);
      foreach (tbl[i]) begin
         rst = tbl[i].rst;
         en = tbl[i].en;
         bus.req = tbl[i].req;
         if (tbl[i].rst || !tbl[i].en) begin
            es = 8'h00;
            ec = 8'hFF;
         end else begin
            es = fdig(tbl[i].src, idx_m);
            ec = ecat(idx_m);
         end
         idx_m = tbl[i].rst ? 0 : (idx_m + 1) % 8;
         step();
         chk($sformatf("row%0d gnt", i), 64'(bus.gnt), 64'(tbl[i].gnt));
         chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'(tbl[i].busy));
         if (tbl[i].busy || tbl[i].rst)
            chk($sformatf("row%0d owner", i), 64'(bus.owner),
                64'(tbl[i].owner));
         chk($sformatf("row%0d seg", i), 64'(seg), 64'(es));
         chk($sformatf("row%0d cat", i), 64'(cat), 64'(ec));
      end

      bus.req = '0;
      t = 0;
      while (bus.busy && t < 20) begin
         step();
         t++;
      end
      chk("drain_busy", 64'(bus.busy), 64'(0));

      bus.req = 3'b100;
      t = 0;
      do begin
         step();
         t++;
      end while (!bus.gnt[2] && t < 5);
      bus.req = '0;
      chk("grant_latency", 64'(t), 64'(1));
      chk("grant_owner", 64'(bus.owner), 64'(2));
      nb = bus.busy ? 1 : 0;
      while (bus.busy && nb < 30) begin
         step();
         if (bus.busy) nb++;
      end
      chk("hold_length", 64'(nb), 64'(HOLD));

`ifdef SEG_BLINK_EN
      rst = 1'b1;
      step();
      step();
      blink_mask = 8'h11;
      rst = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         int  k;
         logic on;
         k = (n - 1) % 8;
         on = (((n - 1) / BH) % 2) == 0;
         step();
         if (!on && blink_mask[k]) begin
            es = 8'h00;
            ec = 8'hFF;
         end else begin
            es = fdig(0, k);
            ec = ecat(k);
         end
         chk($sformatf("blink%0d seg", n), 64'(seg), 64'(es));
         chk($sformatf("blink%0d cat", n), 64'(cat), 64'(ec));
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
